// File: rtl/serial_mod_detect.sv
// Streaming divisibility detector: folds MSB-first digits into a running remainder
// modulo MOD and flags when the value received so far is a multiple of MOD.
module serial_mod_detect #(
  parameter int MOD     = 7,
  parameter int DIGIT_W = 1,
  parameter int CNT_W   = 16,
  localparam int REM_W  = $clog2(MOD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] data_in,
  input  logic               clear,
  output logic               vld,
  output logic [REM_W-1:0]   rem_out,
  output logic [CNT_W-1:0]   beat_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    ACC   = 1'b1
  } state_t;

  localparam logic [REM_W:0]   MOD_W   = (REM_W + 1)'(MOD);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_reg, state_next;
  logic [REM_W-1:0]   rem_reg, rem_next;
  logic               vld_reg, vld_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [DIGIT_W-1:0] digit;
  logic [REM_W-1:0]   base;
  logic [REM_W-1:0]   fold_rem;
  logic [REM_W:0]     fold_t;

  // Gate the digit so an undriven bus during gaps never reaches the fold logic.
  assign digit = in_valid ? data_in : '0;
  assign base  = (clear || state_reg == EMPTY) ? '0 : rem_reg;

  // Shift-and-subtract fold, one bit at a time; 2r+b < 2*MOD so one subtract suffices.
  always_comb begin
    fold_rem = base;
    fold_t   = '0;
    for (int i = DIGIT_W - 1; i >= 0; i--) begin
      fold_t = {fold_rem, digit[i]};
      if (fold_t >= MOD_W) begin
        fold_t = fold_t - MOD_W;
      end
      fold_rem = fold_t[REM_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      rem_reg   <= '0;
      vld_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      vld_reg   <= vld_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    vld_next   = vld_reg;
    cnt_next   = cnt_reg;
    if (in_valid) begin
      // An accepted beat always leaves us holding a number, even when it also clears.
      state_next = ACC;
      rem_next   = fold_rem;
      vld_next   = (fold_rem == '0);
      if (clear) begin
        cnt_next = CNT_W'(1);
      end else if (cnt_reg != CNT_MAX) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else if (clear) begin
      state_next = EMPTY;
      rem_next   = '0;
      vld_next   = 1'b0;
      cnt_next   = '0;
    end
  end

  assign vld      = vld_reg;
  assign rem_out  = rem_reg;
  assign beat_cnt = cnt_reg;

endmodule
